// File: rtl/fetch_unit.sv
// Instruction fetch stage with IF/ID pipeline register for the MIPS core.
// Owns the PC, talks req/ack to instruction memory, redirects on Branch/Jump.
//
// state   | meaning
// IDLE    | no request; launches the first fetch from pc on the next edge
// FETCH   | request outstanding at imem_addr; ack loads IF/ID or the buffer
// HOLD    | IF/ID stalled with a buffered word; no request issued
// DISCARD | waiting out a wrong-path request whose data will be dropped
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        Branch,
  input  logic        Zero,
  input  logic        Jump,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4,
  output logic        instr_valid
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc4_q, buf_pc4_d;
  logic        buf_valid_q, buf_valid_d;

  logic        redirect;
  logic [31:0] target_raw;
  logic [31:0] target;
  logic [31:0] pc_inc;

  always_comb begin
    redirect    = Jump | (Branch & Zero);
    target_raw  = Jump ? jump_target : branch_target;
    target      = target_raw & 32'hFFFF_FFFC;
    pc_inc      = pc_q + 32'd4;

    state_d     = state_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    buf_instr_d = buf_instr_q;
    buf_pc4_d   = buf_pc4_q;
    buf_valid_d = buf_valid_q;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (redirect) begin
          pc_d        = target;
          addr_d      = target;
          valid_d     = 1'b0;
          buf_valid_d = 1'b0;
        end else begin
          addr_d = pc_q;
        end
      end

      FETCH: begin
        if (redirect) begin
          pc_d        = target;
          valid_d     = 1'b0;
          buf_valid_d = 1'b0;
          // Memory cannot cancel, so an unanswered request must be waited out.
          if (imem_ack) begin
            addr_d = target;
          end else begin
            state_d = DISCARD;
          end
        end else if (imem_ack) begin
          pc_d   = pc_inc;
          addr_d = pc_inc;
          if (stall && valid_q) begin
            buf_instr_d = imem_rdata;
            buf_pc4_d   = pc_inc;
            buf_valid_d = 1'b1;
            state_d     = HOLD;
          end else begin
            instr_d = imem_rdata;
            pc4_d   = pc_inc;
            valid_d = 1'b1;
          end
        end else if (!stall) begin
          valid_d = 1'b0;
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_d        = target;
          addr_d      = target;
          valid_d     = 1'b0;
          buf_valid_d = 1'b0;
          state_d     = FETCH;
        end else if (!stall) begin
          instr_d     = buf_instr_q;
          pc4_d       = buf_pc4_q;
          valid_d     = buf_valid_q;
          buf_valid_d = 1'b0;
          addr_d      = pc_q;
          state_d     = FETCH;
        end
      end

      DISCARD: begin
        if (redirect) begin
          pc_d        = target;
          valid_d     = 1'b0;
          buf_valid_d = 1'b0;
        end
        if (imem_ack) begin
          state_d = FETCH;
          addr_d  = pc_d;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    req_d = (state_d == FETCH) || (state_d == DISCARD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      req_q       <= 1'b0;
      instr_q     <= 32'h0000_0000;
      pc4_q       <= 32'h0000_0000;
      valid_q     <= 1'b0;
      buf_instr_q <= 32'h0000_0000;
      buf_pc4_q   <= 32'h0000_0000;
      buf_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      req_q       <= req_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr       = instr_q;
  assign pc_plus4    = pc4_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: latency-programmable memory model feeding
// a scoreboard of expected IF/ID loads, plus directed checks per scenario.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall, Branch, Zero, Jump;
  logic [31:0] branch_target, jump_target;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instr, pc_plus4;
  logic        imem_req2, instr_valid2;
  logic [31:0] imem_addr2, instr2, pc_plus42;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .Branch(Branch), .Zero(Zero), .Jump(Jump),
    .branch_target(branch_target), .jump_target(jump_target),
    .instr(instr), .pc_plus4(pc_plus4), .instr_valid(instr_valid)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .Branch(Branch), .Zero(Zero), .Jump(Jump),
    .branch_target(branch_target), .jump_target(jump_target),
    .instr(instr2), .pc_plus4(pc_plus42), .instr_valid(instr_valid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // memory model
  int          lat;
  int          wcnt;
  logic        mem_en, man_ack, const_word;
  logic        m_ack, req_n;
  logic [31:0] m_rdata, m_addr;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return const_word ? 32'h8C00_0000 : (32'h2000_0000 | a);
  endfunction

  assign imem_ack   = mem_en ? m_ack : man_ack;
  assign imem_rdata = m_rdata;

  initial begin
    m_ack = 1'b0; m_rdata = 32'h0; m_addr = 32'h0; wcnt = 0; req_n = 1'b0;
  end

  always @(negedge clk) begin
    req_n = rst && imem_req;
    if (!rst || !mem_en || !imem_req) begin
      m_ack = 1'b0;
      wcnt  = 0;
    end else if (wcnt + 1 >= lat) begin
      m_ack   = 1'b1;
      m_addr  = imem_addr;
      m_rdata = mem_fn(imem_addr);
      wcnt    = 0;
    end else begin
      m_ack = 1'b0;
      wcnt++;
    end
  end

  // scoreboard and IF/ID monitor
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } sb_t;
  sb_t  sb_q[$];
  logic stale = 1'b0;
  logic p_valid = 1'b0;
  logic [31:0] p_instr = 32'h0, p_pc4 = 32'h0;

  always @(posedge clk) begin
    logic stall_e, redir_e;
    sb_t  e;
    stall_e = stall;
    redir_e = Jump | (Branch & Zero);
    if (!rst) begin
      stale = 1'b0;
    end else if (mem_en && m_ack) begin
      // an ack that coincides with a redirect, or answers a wrong-path request, is dropped
      if (!stale && !redir_e) sb_q.push_back('{instr: m_rdata, pc4: m_addr + 32'd4});
      stale = 1'b0;
    end else if (mem_en && req_n && redir_e) begin
      stale = 1'b1;
    end
    #1;
    if (rst) begin
      if (instr_valid && (!p_valid || !stall_e)) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_unexpected", 32'(instr_valid), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check_eq("sb_instr", instr, e.instr);
          check_eq("sb_pc4", pc_plus4, e.pc4);
        end
      end else if (p_valid && stall_e && !redir_e) begin
        check_eq("hold_valid", 32'(instr_valid), 32'd1);
        check_eq("hold_instr", instr, p_instr);
        check_eq("hold_pc4", pc_plus4, p_pc4);
      end
      p_valid = instr_valid;
      p_instr = instr;
      p_pc4   = pc_plus4;
    end else begin
      p_valid = 1'b0;
    end
  end

  task automatic wait_ack(input int max_cyc);
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!imem_ack && n < max_cyc);
    if (!imem_ack) check_eq("ack_timeout", 32'(imem_ack), 32'd1);
  endtask

  logic [31:0] snap_pc4, snap_instr, stale_addr;

  initial begin
    rst = 1'b0; stall = 1'b0; Branch = 1'b0; Zero = 1'b0; Jump = 1'b0;
    branch_target = 32'h0; jump_target = 32'h0;
    lat = 1; mem_en = 1'b1; man_ack = 1'b0; const_word = 1'b1;

    repeat (2) @(negedge clk);
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_addr", imem_addr, 32'h0);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_pc4", pc_plus4, 32'h0);
    check_eq("rst_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_addr_wrap", imem_addr2, 32'hFFFF_FFF8);

    // streaming with ack tied high
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("seq_addr", imem_addr, 32'(i) * 32'd4);
      check_eq("seq_req", 32'(imem_req), 32'd1);
      if (i < 3) begin
        check_eq("wrap_addr", imem_addr2, 32'hFFFF_FFF8 + 32'(i) * 32'd4);
        check_eq("wrap_req", 32'(imem_req2), 32'd1);
      end
      if (i == 0) begin
        check_eq("first_valid", 32'(instr_valid), 32'd0);
      end else begin
        check_eq("seq_valid", 32'(instr_valid), 32'd1);
        check_eq("seq_instr", instr, 32'h8C00_0000);
        check_eq("seq_pc4", pc_plus4, 32'(i) * 32'd4);
      end
      if (i == 1 || i == 2) begin
        check_eq("wrap_valid", 32'(instr_valid2), 32'd1);
        check_eq("wrap_instr", instr2, 32'h8C00_0000);
        check_eq("wrap_pc4", pc_plus42, 32'hFFFF_FFF8 + 32'(i) * 32'd4);
      end
    end

    // stall for 3 cycles while an ack lands
    const_word = 1'b0;
    repeat (2) @(negedge clk);
    snap_pc4   = pc_plus4;
    snap_instr = instr;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("stall_req", 32'(imem_req), 32'd0);
      check_eq("stall_instr", instr, snap_instr);
    end
    stall = 1'b0;
    @(negedge clk);
    check_eq("unstall_valid", 32'(instr_valid), 32'd1);
    check_eq("unstall_pc4", pc_plus4, snap_pc4 + 32'd4);
    check_eq("unstall_instr", instr, 32'h2000_0000 | snap_pc4);
    @(negedge clk);
    check_eq("unstall_next_pc4", pc_plus4, snap_pc4 + 32'd8);

    // jump with ack in the same cycle
    jump_target = 32'h0000_0040;
    Jump = 1'b1;
    @(negedge clk);
    Jump = 1'b0;
    check_eq("jmp_valid", 32'(instr_valid), 32'd0);
    check_eq("jmp_addr", imem_addr, 32'h0000_0040);
    @(negedge clk);
    check_eq("jmp_instr", instr, 32'h2000_0040);
    check_eq("jmp_pc4", pc_plus4, 32'h0000_0044);

    // taken branch with latency 3, lands while a request is unanswered
    lat = 3;
    wait_ack(10);
    @(negedge clk);
    stale_addr    = imem_addr;
    branch_target = 32'h0000_0101;
    Branch = 1'b1; Zero = 1'b1;
    @(negedge clk);
    Branch = 1'b0; Zero = 1'b0;
    check_eq("disc_req", 32'(imem_req), 32'd1);
    check_eq("disc_addr", imem_addr, stale_addr);
    check_eq("disc_valid", 32'(instr_valid), 32'd0);
    wait_ack(10);
    @(negedge clk);
    check_eq("br_addr", imem_addr, 32'h0000_0100);
    check_eq("br_drop_valid", 32'(instr_valid), 32'd0);
    wait_ack(10);
    @(negedge clk);
    check_eq("br_instr", instr, 32'h2000_0100);
    check_eq("br_pc4", pc_plus4, 32'h0000_0104);

    // branch not taken
    branch_target = 32'h0000_0200;
    Branch = 1'b1; Zero = 1'b0;
    wait_ack(10);
    @(negedge clk);
    check_eq("nobr_addr", imem_addr, 32'h0000_0108);
    check_eq("nobr_pc4", pc_plus4, 32'h0000_0108);
    Branch = 1'b0;

    // async reset mid-request, late ack after release
    lat = 2;
    wait_ack(10);
    @(negedge clk);
    check_eq("sb_empty_pre_rst", 32'(sb_q.size()), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_req", 32'(imem_req), 32'd0);
    check_eq("arst_addr", imem_addr, 32'h0);
    check_eq("arst_instr", instr, 32'h0);
    check_eq("arst_pc4", pc_plus4, 32'h0);
    check_eq("arst_valid", 32'(instr_valid), 32'd0);
    mem_en = 1'b0;
    repeat (2) @(negedge clk);
    man_ack = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    mem_en  = 1'b1;
    check_eq("late_addr", imem_addr, 32'h0);
    check_eq("late_req", 32'(imem_req), 32'd1);
    check_eq("late_valid", 32'(instr_valid), 32'd0);
    wait_ack(10);
    @(negedge clk);
    check_eq("restart_instr", instr, 32'h2000_0000);
    check_eq("restart_pc4", pc_plus4, 32'h0000_0004);

    @(negedge clk);
    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
